mc_controller: RTL and testbench



---
 rtl/mc_controller.sv | 253 +++++++++++++++++++++++++
 tb/tb_mc_controller.sv | 326 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mc_controller.sv
// Multi-cycle MIPS-subset control FSM with memory req/ack handshake.
// Optional retired-instruction counter port when MC_RETIRE_CNT_EN is defined.
module mc_controller (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [5:0]  opcode,
    input  logic [5:0]  func,
    input  logic        zero,
    input  logic        gtz,
    input  logic        mem_ack,
    output logic        mem_req,
    output logic        mem_we,
    output logic        iord,
    output logic        ir_we,
    output logic        pc_en,
    output logic [1:0]  pc_src,
    output logic        reg_we,
    output logic [1:0]  reg_dst,
    output logic [1:0]  wb_src,
    output logic        alu_src_a,
    output logic [1:0]  alu_src_b,
    output logic [2:0]  alu_ctrl,
    output logic [1:0]  ext_op,
    output logic [1:0]  dm_mode,
`ifdef MC_RETIRE_CNT_EN
    output logic [31:0] instr_cnt,
`endif
    output logic        illegal
);

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BGTZ  = 6'b000111;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_LUI   = 6'b001111;
    localparam logic [5:0] OP_LB    = 6'b100000;
    localparam logic [5:0] OP_LH    = 6'b100001;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SB    = 6'b101000;
    localparam logic [5:0] OP_SH    = 6'b101001;
    localparam logic [5:0] OP_SW    = 6'b101011;

    localparam logic [5:0] FN_ADDU  = 6'b100001;
    localparam logic [5:0] FN_SUBU  = 6'b100011;
    localparam logic [5:0] FN_SLLV  = 6'b000100;
    localparam logic [5:0] FN_JR    = 6'b001000;

    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_BR, S_JMP
    } state_e;

    typedef enum logic [4:0] {
        K_ILL, K_ADDU, K_SUBU, K_SLLV, K_ORI, K_LUI,
        K_LW, K_LB, K_LH, K_SW, K_SB, K_SH,
        K_BEQ, K_BGTZ, K_J, K_JAL, K_JR
    } kind_e;

    state_e state_q, state_d;
    kind_e  kind;

    logic is_rtype, is_load, is_store, is_branch, is_jump, is_exec;
    logic [1:0] dm_sel;

    always_comb begin
        kind = K_ILL;
        case (opcode)
            OP_RTYPE: begin
                case (func)
                    FN_ADDU: kind = K_ADDU;
                    FN_SUBU: kind = K_SUBU;
                    FN_SLLV: kind = K_SLLV;
                    FN_JR:   kind = K_JR;
                    default: kind = K_ILL;
                endcase
            end
            OP_J:    kind = K_J;
            OP_JAL:  kind = K_JAL;
            OP_BEQ:  kind = K_BEQ;
            OP_BGTZ: kind = K_BGTZ;
            OP_ORI:  kind = K_ORI;
            OP_LUI:  kind = K_LUI;
            OP_LB:   kind = K_LB;
            OP_LH:   kind = K_LH;
            OP_LW:   kind = K_LW;
            OP_SB:   kind = K_SB;
            OP_SH:   kind = K_SH;
            OP_SW:   kind = K_SW;
            default: kind = K_ILL;
        endcase
    end

    always_comb begin
        is_rtype  = (kind == K_ADDU) || (kind == K_SUBU) || (kind == K_SLLV);
        is_load   = (kind == K_LW) || (kind == K_LB) || (kind == K_LH);
        is_store  = (kind == K_SW) || (kind == K_SB) || (kind == K_SH);
        is_branch = (kind == K_BEQ) || (kind == K_BGTZ);
        is_jump   = (kind == K_J) || (kind == K_JAL) || (kind == K_JR);
        is_exec   = is_rtype || is_load || is_store
                    || (kind == K_ORI) || (kind == K_LUI);
        dm_sel    = 2'b00;
        if ((kind == K_LB) || (kind == K_SB)) begin
            dm_sel = 2'b01;
        end else if ((kind == K_LH) || (kind == K_SH)) begin
            dm_sel = 2'b10;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        iord      = 1'b0;
        ir_we     = 1'b0;
        pc_en     = 1'b0;
        pc_src    = 2'b00;
        reg_we    = 1'b0;
        reg_dst   = 2'b00;
        wb_src    = 2'b00;
        alu_src_a = 1'b0;
        alu_src_b = 2'b00;
        alu_ctrl  = 3'b000;
        ext_op    = 2'b00;
        dm_mode   = 2'b00;
        illegal   = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                state_d = S_FETCH;
            end
            S_FETCH: begin
                mem_req   = 1'b1;
                alu_src_b = 2'b01;
                alu_ctrl  = 3'b010;
                if (mem_ack) begin
                    ir_we   = 1'b1;
                    pc_en   = 1'b1;
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                // Branch target is precomputed here so BR only compares.
                alu_src_b = 2'b11;
                alu_ctrl  = 3'b010;
                if (is_exec) begin
                    state_d = S_EXEC;
                end else if (is_branch) begin
                    state_d = S_BR;
                end else if (is_jump) begin
                    state_d = S_JMP;
                end else begin
                    illegal = 1'b1;
                    state_d = S_FETCH;
                end
            end
            S_EXEC: begin
                alu_src_a = 1'b1;
                state_d   = S_WB;
                if (is_rtype) begin
                    alu_src_b = 2'b00;
                    if (kind == K_SUBU) begin
                        alu_ctrl = 3'b011;
                    end else if (kind == K_SLLV) begin
                        alu_ctrl = 3'b101;
                    end else begin
                        alu_ctrl = 3'b010;
                    end
                end else if (kind == K_ORI) begin
                    alu_src_b = 2'b10;
                    ext_op    = 2'b01;
                    alu_ctrl  = 3'b001;
                end else if (kind == K_LUI) begin
                    alu_src_b = 2'b10;
                    ext_op    = 2'b10;
                    alu_ctrl  = 3'b100;
                end else begin
                    alu_src_b = 2'b10;
                    alu_ctrl  = 3'b010;
                    state_d   = S_MEM;
                end
            end
            S_MEM: begin
                mem_req = 1'b1;
                iord    = 1'b1;
                mem_we  = is_store;
                dm_mode = dm_sel;
                if (mem_ack) begin
                    state_d = is_store ? S_FETCH : S_WB;
                end
            end
            S_WB: begin
                reg_we  = 1'b1;
                state_d = S_FETCH;
                if (is_rtype) begin
                    reg_dst = 2'b01;
                end else if (is_load) begin
                    wb_src = 2'b01;
                end
            end
            S_BR: begin
                alu_src_a = 1'b1;
                alu_ctrl  = 3'b011;
                pc_src    = 2'b01;
                pc_en     = (kind == K_BEQ) ? zero : gtz;
                state_d   = S_FETCH;
            end
            S_JMP: begin
                pc_en   = 1'b1;
                pc_src  = (kind == K_JR) ? 2'b11 : 2'b10;
                state_d = S_FETCH;
                if (kind == K_JAL) begin
                    reg_we  = 1'b1;
                    reg_dst = 2'b10;
                    wb_src  = 2'b10;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

`ifdef MC_RETIRE_CNT_EN
    logic [31:0] cnt_q, cnt_d;
    logic        retire;

    always_comb begin
        retire = (state_d == S_FETCH)
                 && (state_q != S_FETCH)
                 && (state_q != S_IDLE);
        cnt_d  = retire ? cnt_q + 32'd1 : cnt_q;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= 32'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign instr_cnt = cnt_q;
`endif

endmodule

// File: tb/tb_mc_controller.sv
// Self-checking bench for mc_controller: per-cycle outputs against a
// per-instruction schedule model, directed cases plus randomized programs.
module tb_mc_controller;

    typedef struct packed {
        logic       mem_req;
        logic       mem_we;
        logic       iord;
        logic       ir_we;
        logic       pc_en;
        logic [1:0] pc_src;
        logic       reg_we;
        logic [1:0] reg_dst;
        logic [1:0] wb_src;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [2:0] alu_ctrl;
        logic [1:0] ext_op;
        logic [1:0] dm_mode;
        logic       illegal;
    } ov_t;

    localparam int K_ILL = 0, K_ADDU = 1, K_SUBU = 2, K_SLLV = 3;
    localparam int K_ORI = 4, K_LUI = 5, K_LW = 6, K_LB = 7, K_LH = 8;
    localparam int K_SW = 9, K_SB = 10, K_SH = 11, K_BEQ = 12;
    localparam int K_BGTZ = 13, K_J = 14, K_JAL = 15, K_JR = 16;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic [5:0] opcode = 6'd0;
    logic [5:0] func = 6'd0;
    logic       zero = 1'b0;
    logic       gtz = 1'b0;
    logic       mem_ack = 1'b0;
    logic       mem_req, mem_we, iord, ir_we, pc_en;
    logic [1:0] pc_src, reg_dst, wb_src, alu_src_b, ext_op, dm_mode;
    logic       reg_we, alu_src_a, illegal;
    logic [2:0] alu_ctrl;
`ifdef MC_RETIRE_CNT_EN
    logic [31:0] instr_cnt;
`endif

    mc_controller dut (
        .clk(clk), .reset_n(reset_n), .opcode(opcode), .func(func),
        .zero(zero), .gtz(gtz), .mem_ack(mem_ack),
        .mem_req(mem_req), .mem_we(mem_we), .iord(iord),
        .ir_we(ir_we), .pc_en(pc_en), .pc_src(pc_src),
        .reg_we(reg_we), .reg_dst(reg_dst), .wb_src(wb_src),
        .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
        .alu_ctrl(alu_ctrl), .ext_op(ext_op), .dm_mode(dm_mode),
`ifdef MC_RETIRE_CNT_EN
        .instr_cnt(instr_cnt),
`endif
        .illegal(illegal)
    );

    always #5 clk = ~clk;

    ov_t obs;
    assign obs = {mem_req, mem_we, iord, ir_we, pc_en, pc_src, reg_we,
                  reg_dst, wb_src, alu_src_a, alu_src_b, alu_ctrl,
                  ext_op, dm_mode, illegal};

    int          n_chk = 0;
    int          n_fail = 0;
    logic [31:0] exp_cnt = 32'd0;
    ov_t         last_obs;

    task automatic check(input string name, input logic [31:0] got,
                         input logic [31:0] want);
        n_chk++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %h want %h (t=%0t)", name, got, want,
                     $time);
        end
    endtask

    function automatic logic rbit();
        return $urandom_range(0, 1) == 1;
    endfunction

    // Entered at posedge+1; compares at the following negedge.
    task automatic step(input ov_t e, input logic ack);
        mem_ack = ack;
        @(negedge clk);
        check("outputs", obs, e);
`ifdef MC_RETIRE_CNT_EN
        check("instr_cnt", instr_cnt, exp_cnt);
`endif
        last_obs = obs;
        @(posedge clk);
        #1;
    endtask

    function automatic int kind_of(input logic [5:0] op,
                                   input logic [5:0] fn);
        case (op)
            6'b000000: begin
                case (fn)
                    6'b100001: return K_ADDU;
                    6'b100011: return K_SUBU;
                    6'b000100: return K_SLLV;
                    6'b001000: return K_JR;
                    default:   return K_ILL;
                endcase
            end
            6'b000010: return K_J;
            6'b000011: return K_JAL;
            6'b000100: return K_BEQ;
            6'b000111: return K_BGTZ;
            6'b001101: return K_ORI;
            6'b001111: return K_LUI;
            6'b100000: return K_LB;
            6'b100001: return K_LH;
            6'b100011: return K_LW;
            6'b101000: return K_SB;
            6'b101001: return K_SH;
            6'b101011: return K_SW;
            default:   return K_ILL;
        endcase
    endfunction

    function automatic ov_t fetch_v(input logic ack);
        ov_t v = '0;
        v.mem_req = 1'b1;
        v.alu_src_b = 2'b01;
        v.alu_ctrl = 3'b010;
        v.ir_we = ack;
        v.pc_en = ack;
        return v;
    endfunction

    function automatic ov_t mem_v(input int k);
        ov_t v = '0;
        v.mem_req = 1'b1;
        v.iord = 1'b1;
        v.mem_we = (k == K_SW || k == K_SB || k == K_SH);
        if (k == K_LB || k == K_SB) v.dm_mode = 2'b01;
        if (k == K_LH || k == K_SH) v.dm_mode = 2'b10;
        return v;
    endfunction

    function automatic ov_t exec_v(input int k);
        ov_t v = '0;
        v.alu_src_a = 1'b1;
        v.alu_src_b = 2'b10;
        v.alu_ctrl = 3'b010;
        if (k == K_ADDU || k == K_SUBU || k == K_SLLV) begin
            v.alu_src_b = 2'b00;
            v.alu_ctrl = (k == K_ADDU) ? 3'b010 :
                         (k == K_SUBU) ? 3'b011 : 3'b101;
        end else if (k == K_ORI) begin
            v.ext_op = 2'b01;
            v.alu_ctrl = 3'b001;
        end else if (k == K_LUI) begin
            v.ext_op = 2'b10;
            v.alu_ctrl = 3'b100;
        end
        return v;
    endfunction

    task automatic run_instr(input logic [5:0] op, input logic [5:0] fn,
                             input int fw, input int mw, input logic z,
                             input logic g, output int ncyc);
        int  k;
        ov_t e;
        opcode = op;
        func = fn;
        zero = z;
        gtz = g;
        k = kind_of(op, fn);
        ncyc = 0;
        for (int i = 0; i < fw; i++) begin
            step(fetch_v(1'b0), 1'b0);
            ncyc++;
        end
        step(fetch_v(1'b1), 1'b1);
        ncyc++;
        e = '0;
        e.alu_src_b = 2'b11;
        e.alu_ctrl = 3'b010;
        e.illegal = (k == K_ILL);
        step(e, rbit());
        ncyc++;
        if (k == K_BEQ || k == K_BGTZ) begin
            e = '0;
            e.alu_src_a = 1'b1;
            e.alu_ctrl = 3'b011;
            e.pc_src = 2'b01;
            e.pc_en = (k == K_BEQ) ? z : g;
            step(e, rbit());
            ncyc++;
        end else if (k == K_J || k == K_JAL || k == K_JR) begin
            e = '0;
            e.pc_en = 1'b1;
            e.pc_src = (k == K_JR) ? 2'b11 : 2'b10;
            if (k == K_JAL) begin
                e.reg_we = 1'b1;
                e.reg_dst = 2'b10;
                e.wb_src = 2'b10;
            end
            step(e, rbit());
            ncyc++;
        end else if (k != K_ILL) begin
            step(exec_v(k), rbit());
            ncyc++;
            if (k >= K_LW && k <= K_SH) begin
                for (int i = 0; i < mw; i++) begin
                    step(mem_v(k), 1'b0);
                    ncyc++;
                end
                step(mem_v(k), 1'b1);
                ncyc++;
            end
            if (!(k == K_SW || k == K_SB || k == K_SH)) begin
                e = '0;
                e.reg_we = 1'b1;
                if (k == K_ADDU || k == K_SUBU || k == K_SLLV)
                    e.reg_dst = 2'b01;
                if (k == K_LW || k == K_LB || k == K_LH)
                    e.wb_src = 2'b01;
                step(e, rbit());
                ncyc++;
            end
        end
        exp_cnt = exp_cnt + 32'd1;
    endtask

    task automatic store_with_reset();
        ov_t e;
        opcode = 6'b101011;
        func = 6'd0;
        step(fetch_v(1'b1), 1'b1);
        e = '0;
        e.alu_src_b = 2'b11;
        e.alu_ctrl = 3'b010;
        step(e, 1'b0);
        step(exec_v(K_SW), 1'b0);
        mem_ack = 1'b0;
        @(negedge clk);
        check("mem_stall_outputs", obs, mem_v(K_SW));
        #2;
        reset_n = 1'b0;
        #1;
        check("async_drop_req_we", {30'd0, mem_req, mem_we}, 32'd0);
        exp_cnt = 32'd0;
        @(posedge clk);
        #1;
        step('0, 1'b1);
        reset_n = 1'b1;
        step('0, 1'b1);
    endtask

    logic [5:0] ops[18];
    logic [5:0] fns[18];
    int         nc;
    logic [5:0] rop, rfn;

    initial begin
        ops = '{6'b000000, 6'b000000, 6'b000000, 6'b000000, 6'b000000,
                6'b001101, 6'b001111, 6'b100011, 6'b100000, 6'b100001,
                6'b101011, 6'b101000, 6'b101001, 6'b000100, 6'b000111,
                6'b000010, 6'b000011, 6'b111111};
        fns = '{6'b100001, 6'b100011, 6'b000100, 6'b001000, 6'b100000,
                6'd0, 6'd0, 6'd0, 6'd0, 6'd0, 6'd0, 6'd0, 6'd0, 6'd0,
                6'd0, 6'd0, 6'd0, 6'd0};
        #1;
        step('0, 1'b1);
        step('0, 1'b1);
        reset_n = 1'b1;
        step('0, 1'b1);

        run_instr(6'b000000, 6'b100001, 0, 0, 1'b0, 1'b0, nc);
        check("addu_cycles", nc, 4);
        check("addu_wb", {29'd0, last_obs.reg_we, last_obs.reg_dst},
              32'b101);

        run_instr(6'b100011, 6'd0, 2, 3, 1'b0, 1'b0, nc);
        check("lw_stall_cycles", nc, 10);
        run_instr(6'b100011, 6'd0, 0, 0, 1'b0, 1'b0, nc);
        check("lw_cycles", nc, 5);
        run_instr(6'b101011, 6'd0, 0, 0, 1'b0, 1'b0, nc);
        check("sw_cycles", nc, 4);

        run_instr(6'b000100, 6'd0, 0, 0, 1'b1, 1'b0, nc);
        check("beq_taken", {29'd0, last_obs.pc_en, last_obs.pc_src},
              32'b101);
        check("beq_cycles", nc, 3);
        run_instr(6'b000100, 6'd0, 0, 0, 1'b0, 1'b1, nc);
        check("beq_not_taken", {31'd0, last_obs.pc_en}, 32'd0);
        run_instr(6'b000111, 6'd0, 0, 0, 1'b0, 1'b1, nc);
        check("bgtz_taken", {31'd0, last_obs.pc_en}, 32'd1);

        run_instr(6'b000011, 6'd0, 0, 0, 1'b0, 1'b0, nc);
        check("jal_cycles", nc, 3);
        check("jal_jmp", {24'd0, last_obs.pc_en, last_obs.pc_src,
              last_obs.reg_we, last_obs.reg_dst, last_obs.wb_src},
              32'b1101_1010);

        run_instr(6'b111111, 6'd0, 0, 0, 1'b0, 1'b0, nc);
        check("illegal_cycles", nc, 2);
        check("illegal_flag", {29'd0, last_obs.illegal, last_obs.reg_we,
              last_obs.mem_we}, 32'b100);

        store_with_reset();

        for (int n = 0; n < 300; n++) begin
            int idx;
            idx = $urandom_range(0, 17);
            rop = ops[idx];
            rfn = fns[idx];
            run_instr(rop, rfn, $urandom_range(0, 2), $urandom_range(0, 3),
                      rbit(), rbit(), nc);
        end

        store_with_reset();
        run_instr(6'b001101, 6'd0, 1, 0, 1'b0, 1'b0, nc);
        check("ori_after_reset_cycles", nc, 5);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
